// File: rtl/execute_pipe.sv
// execute_pipe: registered execute stage with ALU, branch resolution,
// iterative multiplier, valid/ready handshake and flush.
module execute_pipe #(
    parameter int DATA_W   = 16,
    parameter int MUL_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [2:0]        in_brch,
    input  logic              in_jal,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_pc_inc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_wb,
    output logic [DATA_W-1:0] out_new_pc,
    output logic              out_taken
);

    localparam int ITER = DATA_W / MUL_STEP;
    localparam int SW   = $clog2(DATA_W);
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic {IDLE, MUL} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] ma;
    logic [DATA_W-1:0] mb;
    logic [DATA_W-1:0] l_new_pc;
    logic [DATA_W-1:0] l_pc_inc;
    logic              l_taken;
    logic              l_jal;

    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] target;
    logic [DATA_W-1:0] new_pc;
    logic              taken;
    logic [DATA_W-1:0] part;
    logic [DATA_W-1:0] acc_nxt;
    logic [DATA_W:0]   sum;
    logic [SW-1:0]     sh;
    logic              accept;
    logic              out_free;
    logic              last;

    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == IDLE) && out_free && !flush;
    assign accept   = in_valid && in_ready;
    assign last     = (cnt == CW'(ITER - 1));

    always_comb begin
        res = '0;
        sum = {1'b0, in_a} + {1'b0, in_b};
        sh  = in_b[SW-1:0];
        case (in_op)
            4'd0:    res = sum[DATA_W-1:0];
            4'd1:    res = in_a - in_b;
            4'd2:    res = in_a & in_b;
            4'd3:    res = in_a | in_b;
            4'd4:    res = in_a ^ in_b;
            4'd5:    res = in_a << sh;
            4'd6:    res = in_a >> sh;
            4'd7:    res = $signed(in_a) >>> sh;
            4'd9:    res[0] = (in_a == in_b);
            4'd10:   res[0] = ($signed(in_a) < $signed(in_b));
            4'd11:   res[0] = ($signed(in_a) <= $signed(in_b));
            4'd12:   res[0] = sum[DATA_W];
            default: res = '0;
        endcase
    end

    always_comb begin
        taken  = 1'b0;
        target = in_pc_inc + in_imm;
        case (in_brch)
            3'd1:    taken = (in_a == '0);
            3'd2:    taken = (in_a != '0);
            3'd3:    taken = in_a[DATA_W-1];
            3'd4:    taken = !in_a[DATA_W-1];
            3'd5:    taken = 1'b1;
            3'd6: begin
                taken  = 1'b1;
                target = in_a + in_imm;
            end
            default: taken = 1'b0;
        endcase
        new_pc = taken ? target : in_pc_inc;
    end

    // ma/mb are shifted each iteration so the low MUL_STEP bits of mb
    // always select the next partials.
    always_comb begin
        part = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mb[j]) part = part + (ma << j);
        end
        acc_nxt = acc + part;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            ma         <= '0;
            mb         <= '0;
            l_new_pc   <= '0;
            l_pc_inc   <= '0;
            l_taken    <= 1'b0;
            l_jal      <= 1'b0;
            out_valid  <= 1'b0;
            out_wb     <= '0;
            out_new_pc <= '0;
            out_taken  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && in_op == 4'd8) begin
                        state    <= MUL;
                        cnt      <= '0;
                        acc      <= '0;
                        ma       <= in_a;
                        mb       <= in_b;
                        l_new_pc <= new_pc;
                        l_pc_inc <= in_pc_inc;
                        l_taken  <= taken;
                        l_jal    <= in_jal;
                    end else if (accept) begin
                        out_valid  <= 1'b1;
                        out_wb     <= in_jal ? in_pc_inc : res;
                        out_new_pc <= new_pc;
                        out_taken  <= taken;
                    end
                end
                MUL: begin
                    if (!last) begin
                        acc <= acc_nxt;
                        ma  <= ma << MUL_STEP;
                        mb  <= mb >> MUL_STEP;
                        cnt <= cnt + 1'b1;
                    end else if (out_free) begin
                        out_valid  <= 1'b1;
                        out_wb     <= l_jal ? l_pc_inc : acc_nxt;
                        out_new_pc <= l_new_pc;
                        out_taken  <= l_taken;
                        acc        <= acc_nxt;
                        cnt        <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe: directed and randomized checks of execute_pipe
// against a behavioural reference model and scoreboard.
module tb_execute_pipe;

    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] wb;
        logic [DW-1:0] npc;
        logic          taken;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_op = '0;
    logic [2:0]    in_brch = '0;
    logic          in_jal = 1'b0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic [DW-1:0] in_imm = '0;
    logic [DW-1:0] in_pc_inc = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_wb;
    logic [DW-1:0] out_new_pc;
    logic          out_taken;

    int tests = 0;
    int fails = 0;

    execute_pipe #(.DATA_W(DW), .MUL_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_brch(in_brch), .in_jal(in_jal),
        .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
        .in_pc_inc(in_pc_inc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wb(out_wb), .out_new_pc(out_new_pc),
        .out_taken(out_taken)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(
        input logic [3:0] op, input logic [2:0] br, input logic jal,
        input logic [DW-1:0] a, input logic [DW-1:0] b,
        input logic [DW-1:0] imm, input logic [DW-1:0] pc);
        exp_t e;
        logic [DW-1:0] r;
        logic [2*DW-1:0] p;
        logic [DW:0] s;
        int sa;
        sa = int'(b[3:0]);
        p = {16'b0, a} * {16'b0, b};
        s = {1'b0, a} + {1'b0, b};
        r = '0;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << sa;
            4'd6: r = a >> sa;
            4'd7: r = $signed(a) >>> sa;
            4'd8: r = p[DW-1:0];
            4'd9: r = {15'b0, a == b};
            4'd10: r = {15'b0, $signed(a) < $signed(b)};
            4'd11: r = {15'b0, $signed(a) <= $signed(b)};
            4'd12: r = {15'b0, s[DW]};
            default: r = '0;
        endcase
        case (br)
            3'd1: e.taken = (a == 0);
            3'd2: e.taken = (a != 0);
            3'd3: e.taken = a[DW-1];
            3'd4: e.taken = !a[DW-1];
            3'd5, 3'd6: e.taken = 1'b1;
            default: e.taken = 1'b0;
        endcase
        if (!e.taken) e.npc = pc;
        else if (br == 3'd6) e.npc = a + imm;
        else e.npc = pc + imm;
        e.wb = jal ? pc : r;
        return e;
    endfunction

    task automatic set_op(input logic [3:0] op, input logic [2:0] br,
                          input logic jal, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [DW-1:0] imm,
                          input logic [DW-1:0] pc);
        in_op = op; in_brch = br; in_jal = jal;
        in_a = a; in_b = b; in_imm = imm; in_pc_inc = pc;
    endtask

    task automatic send(input logic [3:0] op, input logic [2:0] br,
                        input logic jal, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] imm,
                        input logic [DW-1:0] pc);
        int cyc;
        set_op(op, br, jal, a, b, imm, pc);
        in_valid = 1'b1;
        cyc = 0;
        #1;
        while (!in_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (!in_ready) begin
            fails++;
            $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        out_ready = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if ({out_valid, out_wb, out_new_pc, out_taken} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b wb=%h pc=%h t=%b want 0",
                     out_valid, out_wb, out_new_pc, out_taken);
        end
        #10 rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        send(4'd0, 3'd0, 1'b0, 16'h7FFF, 16'h0001, 16'h0000, 16'h0010);
        @(negedge clk);
        tests++;
        if ({out_valid, out_wb, out_new_pc, out_taken} !==
            {1'b1, 16'h8000, 16'h0010, 1'b0}) begin
            fails++;
            $display("FAIL add: got v=%b wb=%h pc=%h t=%b want 1 8000 0010 0",
                     out_valid, out_wb, out_new_pc, out_taken);
        end
        send(4'd0, 3'd2, 1'b0, 16'h0003, 16'h0000, 16'hFFF8, 16'h0020);
        @(negedge clk);
        tests++;
        if ({out_taken, out_new_pc} !== {1'b1, 16'h0018}) begin
            fails++;
            $display("FAIL bnez_taken: got t=%b pc=%h want 1 0018",
                     out_taken, out_new_pc);
        end
        send(4'd0, 3'd2, 1'b0, 16'h0000, 16'h0000, 16'hFFF8, 16'h0020);
        @(negedge clk);
        tests++;
        if ({out_taken, out_new_pc} !== {1'b0, 16'h0020}) begin
            fails++;
            $display("FAIL bnez_not: got t=%b pc=%h want 0 0020",
                     out_taken, out_new_pc);
        end
        send(4'd0, 3'd6, 1'b1, 16'h1000, 16'h0000, 16'h0004, 16'h0042);
        @(negedge clk);
        tests++;
        if ({out_new_pc, out_wb, out_taken} !==
            {16'h1004, 16'h0042, 1'b1}) begin
            fails++;
            $display("FAIL jr_jal: got pc=%h wb=%h t=%b want 1004 0042 1",
                     out_new_pc, out_wb, out_taken);
        end
    endtask

    task automatic test_mul();
        int low;
        logic seen;
        idle(2);
        send(4'd8, 3'd0, 1'b0, 16'h0123, 16'h0045, 16'h0000, 16'h0050);
        set_op(4'd0, 3'd0, 1'b0, 16'h0100, 16'h0001, 16'h0000, 16'h0060);
        in_valid = 1'b1;
        low = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else if (!in_ready) low++;
        end
        tests++;
        if (!seen || low != 16) begin
            fails++;
            $display("FAIL mul_latency: got seen=%b low=%0d want 1 16",
                     seen, low);
        end
        tests++;
        if (out_wb !== 16'h4E6F || out_new_pc !== 16'h0050) begin
            fails++;
            $display("FAIL mul_result: got wb=%h pc=%h want 4e6f 0050",
                     out_wb, out_new_pc);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({out_valid, out_wb, out_new_pc} !==
            {1'b1, 16'h0101, 16'h0060}) begin
            fails++;
            $display("FAIL mul_held_op: got v=%b wb=%h pc=%h want 1 0101 0060",
                     out_valid, out_wb, out_new_pc);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        idle(2);
        out_ready = 1'b0;
        send(4'd0, 3'd0, 1'b0, 16'h0011, 16'h0022, 16'h0000, 16'h0030);
        set_op(4'd1, 3'd0, 1'b0, 16'h0005, 16'h0007, 16'h0000, 16'h0032);
        in_valid = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_wb !== 16'h0033 ||
                in_ready !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_hold: got %0d bad cycles wb=%h want 0 0033",
                     bad, out_wb);
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: got in_ready=%b want 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({out_valid, out_wb} !== {1'b1, 16'hFFFE}) begin
            fails++;
            $display("FAIL bp_sub: got v=%b wb=%h want 1 fffe",
                     out_valid, out_wb);
        end
    endtask

    task automatic test_flush();
        int bad;
        idle(2);
        send(4'd8, 3'd0, 1'b0, 16'h0077, 16'h0033, 16'h0000, 16'h0070);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_gate: got in_ready=%b want 0", in_ready);
        end
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle: got rdy=%b v=%b want 1 0",
                     in_ready, out_valid);
        end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL flush_no_result: got %0d valid cycles want 0", bad);
        end
    endtask

    task automatic test_reset_mid_mul();
        int bad;
        idle(2);
        send(4'd0, 3'd5, 1'b0, 16'h1234, 16'h1111, 16'h0100, 16'h0200);
        send(4'd8, 3'd0, 1'b0, 16'h0099, 16'h0011, 16'h0000, 16'h0300);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, out_wb, out_new_pc, out_taken} !== '0) begin
            fails++;
            $display("FAIL rst_async: got v=%b wb=%h pc=%h t=%b want 0",
                     out_valid, out_wb, out_new_pc, out_taken);
        end
        #3 rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_abort: got %0d valid cycles rdy=%b want 0 1",
                     bad, in_ready);
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        int sent;
        int got;
        logic acc;
        sent = 0;
        got = 0;
        idle(2);
        for (int cyc = 0; cyc < 20000 &&
             (sent < 300 || q.size() > 0 || out_valid); cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < 300) begin
                set_op(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), 16'($urandom),
                       16'($urandom), 16'($urandom), 16'($urandom));
                in_valid = 1'b1;
            end
            #1;
            if (out_valid && out_ready) begin
                tests++;
                got++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL rnd_extra: got wb=%h want no output",
                             out_wb);
                end else begin
                    e = q.pop_front();
                    if ({out_wb, out_new_pc, out_taken} !== e) begin
                        fails++;
                        $display("FAIL rnd_out: got %h %h %b want %h %h %b",
                                 out_wb, out_new_pc, out_taken,
                                 e.wb, e.npc, e.taken);
                    end
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(model(in_op, in_brch, in_jal, in_a, in_b,
                                  in_imm, in_pc_inc));
                sent++;
            end
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        tests++;
        if (sent != 300 || got != 300 || q.size() != 0) begin
            fails++;
            $display("FAIL rnd_count: got sent=%0d drained=%0d left=%0d want 300 300 0",
                     sent, got, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mul();
        test_backpressure();
        test_flush();
        test_reset_mid_mul();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
